// File: rtl/reg_rename_ckpt.sv
// reg_rename_ckpt: register rename with RAM map table, circular free list, busy table
// and branch checkpoints giving single-cycle mispredict recovery.
module reg_rename_ckpt #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_CKPT      = 4,
    parameter int AW            = $clog2(NUM_ARCH_REGS),
    parameter int PW            = $clog2(NUM_PHYS_REGS),
    parameter int CW            = $clog2(NUM_CKPT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ren_valid,
    output logic          ren_ready,
    input  logic          ren_uses_rw,
    input  logic [AW-1:0] ren_rw_arch,
    input  logic [AW-1:0] ren_rs_arch,
    input  logic [AW-1:0] ren_rt_arch,
    input  logic          ren_is_branch,
    output logic [PW-1:0] ren_rs_phys,
    output logic [PW-1:0] ren_rt_phys,
    output logic          ren_rs_busy,
    output logic          ren_rt_busy,
    output logic [PW-1:0] ren_rw_phys,
    output logic [PW-1:0] ren_old_rw_phys,
    output logic [CW-1:0] ren_ckpt_id,
    input  logic          wb_valid,
    input  logic [PW-1:0] wb_phys,
    input  logic          commit_valid,
    input  logic [PW-1:0] commit_old_phys,
    input  logic          br_valid,
    input  logic [CW-1:0] br_id,
    input  logic          br_mispredict,
    output logic [PW:0]   free_count
);

    localparam int FREE0 = NUM_PHYS_REGS - NUM_ARCH_REGS;

    logic [PW-1:0]      rmt_q [NUM_ARCH_REGS];
    logic [PW-1:0]      rmt_d [NUM_ARCH_REGS];
    logic [PW-1:0]      fl_q [NUM_PHYS_REGS];
    logic [PW-1:0]      fl_d [NUM_PHYS_REGS];
    logic [PW:0]        head_q, head_d, tail_q, tail_d;
    logic [NUM_PHYS_REGS-1:0] busy_q, busy_d;
    logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
    logic [CW-1:0]      ckpt_tail_q, ckpt_tail_d;
    logic [PW-1:0]      ckpt_rmt_q [NUM_CKPT][NUM_ARCH_REGS];
    logic [PW:0]        ckpt_head_q [NUM_CKPT];

    logic          wr, fire, alloc, push, ckpt_we, br_hit, mispred;
    logic [PW-1:0] new_phys;
    logic [CW-1:0] br_span;

    assign wr       = ren_uses_rw & (ren_rw_arch != '0);
    assign mispred  = br_valid & br_mispredict;
    assign br_hit   = br_valid & ckpt_valid_q[br_id];
    assign ren_ready = !mispred & (!wr | free_count != '0) & (!ren_is_branch | !ckpt_valid_q[ckpt_tail_q]);
    assign fire     = ren_valid & ren_ready;
    assign alloc    = fire & wr;
    assign ckpt_we  = fire & ren_is_branch;
    assign push     = commit_valid & (commit_old_phys != '0);
    assign new_phys = fl_q[head_q[PW-1:0]];
    assign br_span  = ckpt_tail_q - br_id;

    assign free_count      = tail_q - head_q;
    assign ren_rs_phys     = rmt_q[ren_rs_arch];
    assign ren_rt_phys     = rmt_q[ren_rt_arch];
    assign ren_rs_busy     = (ren_rs_phys != '0) & busy_q[ren_rs_phys] & !(wb_valid & wb_phys == ren_rs_phys);
    assign ren_rt_busy     = (ren_rt_phys != '0) & busy_q[ren_rt_phys] & !(wb_valid & wb_phys == ren_rt_phys);
    assign ren_rw_phys     = wr ? new_phys : '0;
    assign ren_old_rw_phys = wr ? rmt_q[ren_rw_arch] : '0;
    assign ren_ckpt_id     = ckpt_tail_q;

    always_comb begin
        rmt_d        = rmt_q;
        fl_d         = fl_q;
        head_d       = head_q;
        tail_d       = tail_q;
        busy_d       = busy_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_tail_d  = ckpt_tail_q;
        if (wb_valid) busy_d[wb_phys] = 1'b0;
        if (alloc) begin
            rmt_d[ren_rw_arch] = new_phys;
            head_d             = head_q + (PW+1)'(1);
            busy_d[new_phys]   = 1'b1;
        end
        if (push) begin
            fl_d[tail_q[PW-1:0]] = commit_old_phys;
            tail_d               = tail_q + (PW+1)'(1);
        end
        if (br_hit & !br_mispredict) ckpt_valid_d[br_id] = 1'b0;
        if (br_hit & br_mispredict) begin
            rmt_d  = ckpt_rmt_q[br_id];
            head_d = ckpt_head_q[br_id];
            // span 0 with br_id valid means the ring is full: every slot is br_id or younger
            for (int k = 0; k < NUM_CKPT; k++)
                if (CW'(CW'(k) - br_id) < br_span || br_span == '0) ckpt_valid_d[k] = 1'b0;
            ckpt_tail_d = br_id;
        end
        if (ckpt_we) begin
            ckpt_valid_d[ckpt_tail_q] = 1'b1;
            ckpt_tail_d               = ckpt_tail_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rmt_q[i] <= PW'(i);
            for (int i = 0; i < NUM_PHYS_REGS; i++) fl_q[i] <= (i < FREE0) ? PW'(NUM_ARCH_REGS + i) : '0;
            head_q       <= '0;
            tail_q       <= (PW+1)'(FREE0);
            busy_q       <= '0;
            ckpt_valid_q <= '0;
            ckpt_tail_q  <= '0;
        end else begin
            rmt_q        <= rmt_d;
            fl_q         <= fl_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            busy_q       <= busy_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_tail_q  <= ckpt_tail_d;
        end
    end

    // Snapshot payload is qualified by ckpt_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ckpt_we) begin
            ckpt_rmt_q[ckpt_tail_q]  <= rmt_d;
            ckpt_head_q[ckpt_tail_q] <= head_d;
        end
    end

endmodule

// File: doc/reg_rename_ckpt.md
Name: reg_rename_ckpt

Overview:
- Parametrised rename stage between decode and the instruction queue.
- Maps architectural source and destination registers to physical registers using a RAM-style map table, a circular free list and a busy-bit table.
- Adds what the first-generation rename logic lacked: ready/valid back-pressure, busy clear on writeback, free-list return on commit, and up to NUM_CKPT branch checkpoints with single-cycle mispredict recovery.

Parameters:
NUM_ARCH_REGS, 32, architectural register count; arch reg 0 is hardwired and never renamed
NUM_PHYS_REGS, 64, physical register count; must exceed NUM_ARCH_REGS
NUM_CKPT, 4, branch checkpoint slots; power of 2
AW, $clog2(NUM_ARCH_REGS), architectural index width
PW, $clog2(NUM_PHYS_REGS), physical index width
CW, $clog2(NUM_CKPT), checkpoint id width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ren_valid  in  1  decoded instruction present
ren_ready  out  1  rename can accept this cycle
ren_uses_rw / ren_rw_arch  in  1 / AW  destination used / destination index
ren_rs_arch / ren_rt_arch  in  AW / AW  source indices
ren_is_branch  in  1  instruction needs a checkpoint
ren_rs_phys / ren_rt_phys  out  PW / PW  renamed sources
ren_rs_busy / ren_rt_busy  out  1 / 1  source not yet written back
ren_rw_phys / ren_old_rw_phys  out  PW / PW  new destination / previous mapping (travels to commit)
ren_ckpt_id  out  CW  allocated checkpoint id
wb_valid / wb_phys  in  1 / PW  writeback; clears busy bit
commit_valid / commit_old_phys  in  1 / PW  commit; returns old mapping to free list
br_valid / br_id / br_mispredict  in  1 / CW / 1  branch resolution
free_count  out  PW+1  free-list occupancy

Behaviour:
- Reset (async): rmt[i]=i; free list holds NUM_ARCH_REGS..NUM_PHYS_REGS-1 in order, head=0, tail=NUM_PHYS_REGS-NUM_ARCH_REGS; free_count=NUM_PHYS_REGS-NUM_ARCH_REGS; busy all 0; all checkpoints invalid; ckpt_tail=0.
- Reset mid-operation discards all state immediately.
- Rename outputs are combinational from the current state, available in the same cycle. fire = ren_valid & ren_ready. State updates on the posedge.
- Destination write: wr = ren_uses_rw & (ren_rw_arch != 0).
- On a fire with wr:
  - ren_rw_phys = free list head entry; head advances.
  - busy[new] is set.
  - rmt[rw_arch] is updated.
  - ren_old_rw_phys = prior rmt[rw_arch].
- Without wr: ren_rw_phys = 0, ren_old_rw_phys = 0.
- Sources read the rmt before this instruction's own update.
- ren_*_busy = busy[phys] & !(wb_valid & wb_phys==phys), i.e. same-cycle writeback bypass. Phys 0 always reads not-busy.
- ren_ready = !(br_valid & br_mispredict) & (!wr | free_count!=0) & (!ren_is_branch | !ckpt_valid[ckpt_tail]).
- Checkpoint on a fire with ren_is_branch:
  - slot ckpt_tail stores the post-update rmt and the post-advance free-list head.
  - The slot is marked valid; ren_ckpt_id = ckpt_tail; ckpt_tail increments mod NUM_CKPT.
- Free-list pointers are PW+1 bits with a wrap bit; storage is NUM_PHYS_REGS entries.
  - free_count = tail - head.
  - Commit pushes commit_old_phys at tail, unless it is 0.
- Branch resolves correct (br_valid & !br_mispredict): ckpt_valid[br_id] is cleared.
- Branch mispredicts:
  - rmt = ckpt[br_id].rmt; free-list head = ckpt[br_id].head.
  - br_id and all younger slots, from br_id up to ckpt_tail-1 circularly, are invalidated.
  - ckpt_tail = br_id.
  - The busy table is untouched; stale bits are overwritten on reallocation.
- Upstream suppresses writeback of squashed instructions.
- Simultaneous events:
  - alloc + commit: free_count is unchanged.
  - mispredict + commit: the commit push still applies, and the restored head is combined with the new tail.
  - alloc + wb to a different phys: both apply.
  - br_valid targeting an invalid slot is ignored.

Test Plan:
- Reset, rename add r5 (rs=r1, rt=r2) -> rs_phys=1, rt_phys=2, rw_phys=32, old=5, free_count 31; next rename reading r5 -> rs_phys=32, rs_busy=1.
- wb_phys=32 asserted in the same cycle as rename reading r5 -> rs_busy=0; following cycle busy[32]=0.
- Rename 32 writes with no commit -> free_count=0, ren_ready=0 for the next write; a non-writing instruction is still accepted. Then commit_old_phys=5 -> ready again next cycle, next rw_phys=5.
- Branch (ckpt 0), rename r3->33, r4->34, mispredict br_id=0 -> rmt[3]=3, rmt[4]=4, free_count restored to 31, ren_ready=0 in the mispredict cycle, next allocation is 33.
- Fill all 4 checkpoints -> branch stalls; resolve id 1 correct -> still stalled (tail slot 0 valid); resolve id 0 -> branch accepted with id 0.
- Mispredict on id 1 with ids 2,3 valid -> ids 1..3 invalid, ckpt_tail=1; commit of phys 7 in the same cycle -> free_count = restored count + 1.
